// File: rtl/vector_v_pkg.sv
// Shared constants for the vector_v scheduler: byte/nibble widths and the
// output-stage state encoding.
package vector_v_pkg;
   localparam int VV_DATA_W = 8;
   localparam int VV_NIB_W  = 4;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;
endpackage

// File: rtl/vector_v_slice.sv
// Combinational byte slicer: parity, high nibble, and the byte itself on a
// bit-reversed-index bus (bus value equals the input byte).
module vector_v_slice
   import vector_v_pkg::*;
(
   input  logic [VV_DATA_W-1:0] data,
   output logic                 res1,
   output logic [VV_NIB_W-1:0]  res2,
   output logic [0:VV_DATA_W-1] res3
);
   assign res1 = ^data;
   assign res2 = data[VV_DATA_W-1 -: VV_NIB_W];
   // Left-to-right assignment puts data[7] on res3[0].
   assign res3 = data;
endmodule

// File: rtl/vector_v_sched.sv
// Round-robin scheduler: grants one byte producer per cycle into a shared
// slicer and registers the result in a single-entry valid/ready stage.
module vector_v_sched
   import vector_v_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [VV_DATA_W*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_res1,
   output logic [VV_NIB_W-1:0]            out_res2,
   output logic [0:VV_DATA_W-1]           out_res3,
   output logic [SRC_W-1:0]               out_src,
   output logic [CNT_W-1:0]               xfer_cnt,
   output logic                           busy
);
   logic [0:0]            state_q, state_d;
   logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]      src_q, src_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  res1_q, res1_d;
   logic [VV_NIB_W-1:0]   res2_q, res2_d;
   logic [0:VV_DATA_W-1]  res3_q, res3_d;

   logic                  found, can_accept, xfer;
   logic [SRC_W-1:0]      winner;
   logic [VV_DATA_W-1:0]  win_data;
   logic                  s_res1;
   logic [VV_NIB_W-1:0]   s_res2;
   logic [0:VV_DATA_W-1]  s_res3;

   assign out_valid  = (state_q == ST_FULL);
   assign can_accept = en && (!out_valid || out_ready);
   assign xfer       = can_accept && found;

   // Scan starting at rr_ptr; first valid requester wins, no lock held.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = SRC_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == SRC_W'(i)) begin
            req_ready[i] = xfer;
            win_data     = req_data[VV_DATA_W*i +: VV_DATA_W];
         end
      end
   end

   vector_v_slice u_slice (
      .data (win_data),
      .res1 (s_res1),
      .res2 (s_res2),
      .res3 (s_res3)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      src_d    = src_q;
      cnt_d    = cnt_q;
      res1_d   = res1_q;
      res2_d   = res2_q;
      res3_d   = res3_q;
      if (xfer) begin
         state_d  = ST_FULL;
         rr_ptr_d = (int'(winner) == NUM_REQ-1) ? '0 : winner + SRC_W'(1);
         src_d    = winner;
         cnt_d    = cnt_q + CNT_W'(1);
         res1_d   = s_res1;
         res2_d   = s_res2;
         res3_d   = s_res3;
      end else if (state_q == ST_FULL && out_ready) begin
         state_d  = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         src_q    <= '0;
         cnt_q    <= '0;
         res1_q   <= 1'b0;
         res2_q   <= '0;
         res3_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         src_q    <= src_d;
         cnt_q    <= cnt_d;
         res1_q   <= res1_d;
         res2_q   <= res2_d;
         res3_q   <= res3_d;
      end
   end

   assign out_res1 = res1_q;
   assign out_res2 = res2_q;
   assign out_res3 = res3_q;
   assign out_src  = src_q;
   assign xfer_cnt = cnt_q;
   assign busy     = out_valid || (|req_valid);
endmodule

// File: tb/tb_vector_v_sched.sv
// Scoreboard bench for vector_v_sched: directed stimulus pushes hand-computed
// results; a monitor pops and compares on every consumed output.
module tb_vector_v_sched;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_res1;
   logic [3:0]  out_res2;
   logic [0:7]  out_res3;
   logic [1:0]  out_src;
   logic [15:0] xfer_cnt;
   logic        busy;

   typedef struct packed {
      logic        r1;
      logic [3:0]  r2;
      logic [7:0]  r3;
      logic [1:0]  src;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_cnt = '0;
   int          n_chk = 0;
   int          n_pass = 0;

   vector_v_sched #(.NUM_REQ(4), .SRC_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_res1(out_res1), .out_res2(out_res2), .out_res3(out_res3),
      .out_src(out_src), .xfer_cnt(xfer_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic push(input logic [7:0] d, input logic r1, input logic [3:0] r2,
                       input logic [1:0] src);
      exp_cnt = exp_cnt + 16'd1;
      sb.push_back({r1, r2, d, src, exp_cnt});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_cnt = '0;
      sb.delete();
   endtask

   // Monitor: every consumed result must match the oldest expected entry.
   initial begin
      exp_t e;
      logic [7:0] r3v;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            r3v = out_res3;
            n_chk++;
            if (sb.size() == 0) begin
               $display("FAIL result: unexpected output src=%0d data=%0h", out_src, r3v);
            end else begin
               e = sb.pop_front();
               if ({out_res1, out_res2, r3v, out_src, xfer_cnt} === e) n_pass++;
               else $display("FAIL result: got r1=%0d r2=%0h r3=%0h src=%0d cnt=%0h expected r1=%0d r2=%0h r3=%0h src=%0d cnt=%0h",
                             out_res1, out_res2, r3v, out_src, xfer_cnt,
                             e.r1, e.r2, e.r3, e.src, e.cnt);
            end
         end
      end
   end

   initial begin
      logic [3:0] gseq [5];
      gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      do_reset();
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_res", {19'd0, out_res1, out_res2, out_res3}, 32'd0);

      // Single transfer of 0xA5 from req0.
      step();
      en = 1'b1; out_ready = 1'b1;
      req_valid = 4'b0001; req_data[7:0] = 8'hA5;
      @(negedge clk);
      chk("t1_grant", {28'd0, req_ready}, 32'h1);
      push(8'hA5, 1'b0, 4'hA, 2'd0);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      step();
      @(negedge clk);
      chk("t1_drain", {31'd0, out_valid}, 32'd0);

      // All four valid from rr_ptr=0: grants 0,1,2,3,0 with no bubbles.
      do_reset();
      req_valid = 4'b1111;
      req_data = {8'hFF, 8'h3C, 8'h10, 8'h07};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rr_grant", {28'd0, req_ready}, {28'd0, gseq[c]});
         if (c > 0) chk("rr_nobubble", {31'd0, out_valid}, 32'd1);
         case (c)
            0, 4: push(8'h07, 1'b1, 4'h0, 2'd0);
            1:    push(8'h10, 1'b1, 4'h1, 2'd1);
            2:    push(8'h3C, 1'b0, 4'h3, 2'd2);
            default: push(8'hFF, 1'b0, 4'hF, 2'd3);
         endcase
         step();
      end
      req_valid = '0;
      step();

      // Backpressure: result from req1 held while req2 waits.
      req_valid = 4'b0010; req_data[15:8] = 8'h80;
      @(negedge clk);
      chk("bp_grant1", {28'd0, req_ready}, 32'h2);
      push(8'h80, 1'b1, 4'h8, 2'd1);
      step();
      req_valid = 4'b0100; req_data[23:16] = 8'h55; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_noready", {28'd0, req_ready}, 32'h0);
         chk("bp_hold", {24'd0, out_valid, out_res1, out_res2, out_src},
             {24'd0, 1'b1, 1'b1, 4'h8, 2'd1});
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_grant2", {28'd0, req_ready}, 32'h4);
      push(8'h55, 1'b0, 4'h5, 2'd2);
      step();
      req_valid = '0;
      step();

      // en=0: pending result drains, no grant until en returns.
      req_valid = 4'b1000; req_data[31:24] = 8'h01;
      @(negedge clk);
      chk("en_load", {28'd0, req_ready}, 32'h8);
      push(8'h01, 1'b1, 4'h0, 2'd3);
      step();
      en = 1'b0; out_ready = 1'b0;
      req_valid = 4'b0001; req_data[7:0] = 8'hC3;
      @(negedge clk);
      chk("en_off_ready", {28'd0, req_ready}, 32'h0);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("en_off_drain", {28'd0, req_ready}, 32'h0);
      step();
      @(negedge clk);
      chk("en_off_empty", {31'd0, out_valid}, 32'd0);
      chk("en_off_nogrant", {28'd0, req_ready}, 32'h0);
      step();
      en = 1'b1;
      @(negedge clk);
      chk("en_on_grant", {28'd0, req_ready}, 32'h1);
      push(8'hC3, 1'b0, 4'hC, 2'd0);
      step();

      // Counter wrap: stream zero bytes from req0 until the count reads all-ones.
      req_data[7:0] = 8'h00;
      while (exp_cnt != 16'hFFFF) begin
         @(negedge clk);
         push(8'h00, 1'b0, 4'h0, 2'd0);
         step();
      end
      req_data[7:0] = 8'hE7;
      @(negedge clk);
      chk("wrap_full", {16'd0, xfer_cnt}, 32'hFFFF);
      push(8'hE7, 1'b0, 4'hE, 2'd0);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("wrap_zero", {16'd0, xfer_cnt}, 32'h0);
      step();

      // Async reset with a held result, then restart from rr_ptr=0.
      req_valid = 4'b0100; req_data[23:16] = 8'h11;
      @(negedge clk);
      push(8'h11, 1'b0, 4'h1, 2'd2);
      step();
      req_valid = '0; out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_cnt", {16'd0, xfer_cnt}, 32'd0);
      sb.delete();
      exp_cnt = '0;
      #1 rst_n = 1'b1;
      req_valid = 4'b0110; req_data[15:8] = 8'h80; out_ready = 1'b1;
      @(negedge clk);
      chk("arst_grant", {28'd0, req_ready}, 32'h2);
      push(8'h80, 1'b1, 4'h8, 2'd1);
      step();
      req_valid = '0;
      step();
      step();
      chk("sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
